// File: rtl/vec_pkg.sv
// Shared vector writeback definitions, imported by the writeback serializer,
// the decode-stage hazard unit and the vector register file.
package vec_pkg;

    localparam int LANE_W  = 32;
    localparam int LANES   = 8;
    localparam int REG_AW  = 3;
    localparam int VEC_W   = LANE_W * LANES;
    localparam int LANE_AW = $clog2(LANES);

    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic {
        VWB_IDLE  = 1'b0,
        VWB_DRAIN = 1'b1
    } vwb_state_e;

endpackage

// File: rtl/vec_wb_serializer.sv
// Vector writeback stage: latches one 256-bit result and writes it into the
// 32-bit-wide vector RF one lane per cycle, stalling upstream while draining.
module vec_wb_serializer #(
    parameter int LANE_W = 32,
    parameter int LANES  = 8,
    parameter int REG_AW = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   RegWriteWV,
    input  logic                                   MemtoRegWV,
    input  logic [LANE_W*LANES-1:0]                ReadDataWV,
    input  logic [LANE_W*LANES-1:0]                ALUOutWV,
    input  logic [REG_AW-1:0]                      WA3WV,
    output logic                                   StallWV,
    output logic                                   RFWriteV,
    output logic [REG_AW+$clog2(LANES)-1:0]        RFAddrV,
    output logic [LANE_W-1:0]                      RFDataV,
    output logic                                   PendingV,
    output logic [REG_AW-1:0]                      PendingRegV
);
    import vec_pkg::*;

    localparam int LAW = $clog2(LANES);

    vwb_state_e                r_state;
    vwb_state_e                w_state_nxt;
    logic [LAW-1:0]            r_lane;
    logic [LAW-1:0]            w_lane_nxt;
    logic [LANE_W*LANES-1:0]   r_buf;
    logic [REG_AW-1:0]         r_reg;
    logic                      w_last;
    logic                      w_accept;

    // A new vector may enter when idle or on the final lane of the current one.
    assign w_last   = (r_state == VWB_DRAIN) && (r_lane == LAW'(LANES - 1));
    assign w_accept = RegWriteWV && ((r_state == VWB_IDLE) || w_last);

    // State, lane counter and captured vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= VWB_IDLE;
            r_lane  <= '0;
            r_buf   <= '0;
            r_reg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
            if (w_accept) begin
                r_buf <= MemtoRegWV ? ReadDataWV : ALUOutWV;
                r_reg <= WA3WV;
            end else begin
                r_buf <= r_buf;
                r_reg <= r_reg;
            end
        end
    end

    // Next-state and lane-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        case (r_state)
            VWB_IDLE: begin
                if (RegWriteWV) begin
                    w_state_nxt = VWB_DRAIN;
                    w_lane_nxt  = '0;
                end else begin
                    w_state_nxt = VWB_IDLE;
                    w_lane_nxt  = '0;
                end
            end
            VWB_DRAIN: begin
                if (!w_last) begin
                    w_state_nxt = VWB_DRAIN;
                    w_lane_nxt  = r_lane + LAW'(1);
                end else if (RegWriteWV) begin
                    w_state_nxt = VWB_DRAIN;
                    w_lane_nxt  = '0;
                end else begin
                    w_state_nxt = VWB_IDLE;
                    w_lane_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = VWB_IDLE;
                w_lane_nxt  = '0;
            end
        endcase
    end

    // RF write port and hazard outputs; all outputs read zero when idle.
    always_comb begin
        StallWV     = 1'b0;
        RFWriteV    = 1'b0;
        RFAddrV     = '0;
        RFDataV     = '0;
        PendingV    = 1'b0;
        PendingRegV = '0;
        if (r_state == VWB_DRAIN) begin
            StallWV     = RegWriteWV && !w_last;
            RFWriteV    = 1'b1;
            RFAddrV     = {r_reg, r_lane};
            RFDataV     = r_buf[r_lane*LANE_W +: LANE_W];
            PendingV    = 1'b1;
            PendingRegV = r_reg;
        end else begin
            StallWV     = 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_wb_serializer.sv
// Directed self-checking bench for vec_wb_serializer: table-driven single
// requests plus hand-written back-to-back, stall-hold and mid-drain reset runs.
module tb_vec_wb_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         RegWriteWV;
    logic         MemtoRegWV;
    logic [255:0] ReadDataWV;
    logic [255:0] ALUOutWV;
    logic [2:0]   WA3WV;
    logic         StallWV;
    logic         RFWriteV;
    logic [5:0]   RFAddrV;
    logic [31:0]  RFDataV;
    logic         PendingV;
    logic [2:0]   PendingRegV;

    int n_cmp = 0;
    int n_err = 0;

    vec_wb_serializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegWriteWV  (RegWriteWV),
        .MemtoRegWV  (MemtoRegWV),
        .ReadDataWV  (ReadDataWV),
        .ALUOutWV    (ALUOutWV),
        .WA3WV       (WA3WV),
        .StallWV     (StallWV),
        .RFWriteV    (RFWriteV),
        .RFAddrV     (RFAddrV),
        .RFDataV     (RFDataV),
        .PendingV    (PendingV),
        .PendingRegV (PendingRegV)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [2:0]  wa;
        logic [31:0] rd_base;
        logic [31:0] alu_base;
        logic        exp_wr;
        logic [2:0]  exp_reg;
        logic [31:0] exp_data0;
    } vec_rec_t;

    vec_rec_t tbl [5];

    function automatic logic [255:0] mkvec(input logic [31:0] base);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + 32'(k);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".stall"}, 32'(StallWV),     32'd0);
        chk({nm, ".we"},    32'(RFWriteV),    32'd0);
        chk({nm, ".addr"},  32'(RFAddrV),     32'd0);
        chk({nm, ".data"},  RFDataV,          32'd0);
        chk({nm, ".pend"},  32'(PendingV),    32'd0);
        chk({nm, ".preg"},  32'(PendingRegV), 32'd0);
    endtask

    task automatic chk_write(input string nm, input logic [2:0] rg, input int ln,
                             input logic [31:0] dat, input logic stall);
        chk({nm, ".stall"}, 32'(StallWV),     32'(stall));
        chk({nm, ".we"},    32'(RFWriteV),    32'd1);
        chk({nm, ".addr"},  32'(RFAddrV),     32'({rg, 3'(ln)}));
        chk({nm, ".data"},  RFDataV,          dat);
        chk({nm, ".pend"},  32'(PendingV),    32'd1);
        chk({nm, ".preg"},  32'(PendingRegV), 32'(rg));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rw, input logic m2r, input logic [2:0] wa,
                       input logic [31:0] rd_base, input logic [31:0] alu_base);
        RegWriteWV = rw;
        MemtoRegWV = m2r;
        WA3WV      = wa;
        ReadDataWV = mkvec(rd_base);
        ALUOutWV   = mkvec(alu_base);
    endtask

    task automatic drop;
        req(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 3'd3, 32'h5555_0000, 32'h1000_0000, 1'b1, 3'd3, 32'h1000_0000};
        tbl[1] = '{1'b1, 1'b1, 3'd0, 32'hDEAD_0000, 32'hFFFF_FFF0, 1'b1, 3'd0, 32'hDEAD_0000};
        tbl[2] = '{1'b0, 1'b1, 3'd6, 32'hAAAA_0000, 32'hBBBB_0000, 1'b0, 3'd0, 32'h0000_0000};
        tbl[3] = '{1'b0, 1'b0, 3'd2, 32'hCCCC_0000, 32'hEEEE_0000, 1'b0, 3'd0, 32'h0000_0000};
        tbl[4] = '{1'b1, 1'b1, 3'd7, 32'h0BAD_F000, 32'h1234_5678, 1'b1, 3'd7, 32'h0BAD_F000};

        rst_n = 1'b0;
        req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick;
        tick;
        chk_idle("reset");
        rst_n = 1'b1;

        // Table of single requests, including ignored RegWriteWV=0 cycles.
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].rw)
                req(1'b1, tbl[i].m2r, tbl[i].wa, tbl[i].rd_base, tbl[i].alu_base);
            else
                req(1'b0, tbl[i].m2r, tbl[i].wa, $urandom, $urandom);
            #1;
            chk_idle($sformatf("v%0d.pre", i));
            tick;
            drop;
            for (int k = 0; k < 8; k++) begin
                #1;
                if (tbl[i].exp_wr)
                    chk_write($sformatf("v%0d.c%0d", i, k + 1), tbl[i].exp_reg, k,
                              tbl[i].exp_data0 + 32'(k), 1'b0);
                else
                    chk_idle($sformatf("v%0d.c%0d", i, k + 1));
                tick;
                RegWriteWV = 1'b0;
            end
            #1;
            chk_idle($sformatf("v%0d.c9", i));
        end

        // Back-to-back: reg 1 then reg 2, continuous write stream.
        req(1'b1, 1'b0, 3'd1, 32'h0, 32'hA100_0000);
        #1;
        chk("b2b.stall0", 32'(StallWV), 32'd0);
        tick;
        req(1'b1, 1'b1, 3'd2, 32'hB200_0000, 32'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_write($sformatf("b2b.a%0d", k), 3'd1, k, 32'hA100_0000 + 32'(k), k != 7);
            tick;
        end
        drop;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_write($sformatf("b2b.b%0d", k), 3'd2, k, 32'hB200_0000 + 32'(k), 1'b0);
            tick;
        end
        #1;
        chk_idle("b2b.end");

        // Stall hold: second request arrives at lane 2, accepted after lane 7.
        req(1'b1, 1'b0, 3'd6, 32'h0, 32'hC600_0000);
        #1;
        tick;
        drop;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) req(1'b1, 1'b1, 3'd5, 32'hD500_0000, 32'h0);
            #1;
            chk_write($sformatf("hold.c%0d", k), 3'd6, k, 32'hC600_0000 + 32'(k),
                      (k >= 2) && (k != 7));
            tick;
        end
        drop;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_write($sformatf("hold.d%0d", k), 3'd5, k, 32'hD500_0000 + 32'(k), 1'b0);
            tick;
        end
        #1;
        chk_idle("hold.end");

        // Reset at lane 4 abandons the vector; the next request restarts at lane 0.
        req(1'b1, 1'b0, 3'd4, 32'h0, 32'hE400_0000);
        #1;
        tick;
        drop;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_write($sformatf("rst.e%0d", k), 3'd4, k, 32'hE400_0000 + 32'(k), 1'b0);
            if (k == 4) rst_n = 1'b0;
            tick;
        end
        #1;
        chk_idle("rst.after");
        rst_n = 1'b1;
        req(1'b1, 1'b1, 3'd7, 32'hF700_0000, 32'h0);
        #1;
        chk("rst.stall", 32'(StallWV), 32'd0);
        tick;
        drop;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_write($sformatf("rst.f%0d", k), 3'd7, k, 32'hF700_0000 + 32'(k), 1'b0);
            tick;
        end
        #1;
        chk_idle("rst.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
